// File: rtl/control_sequencer.sv
// control_sequencer: T-state controller for a small accumulator machine.
// It steps IDLE -> T1..T6 per instruction (HALT after a halt opcode) and
// decodes the 12-bit control word from the current state and ir_op.
// Build option: define SEQ_JMP_EN to enable the jump opcode (T4 = ei + pc_load).
// Without it, the jump opcode runs as a NOP and pc_load stays 0.
module control_sequencer #(
   parameter logic [3:0] OP_LDA = 4'b0000,
   parameter logic [3:0] OP_ADD = 4'b0001,
   parameter logic [3:0] OP_SUB = 4'b0010,
   parameter logic [3:0] OP_JMP = 4'b0011,
   parameter logic [3:0] OP_OUT = 4'b1110,
   parameter logic [3:0] OP_HLT = 4'b1111
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        run,
   input  logic [3:0]  ir_op,
   output logic [11:0] ctrl_word,
   output logic        pc_load,
   output logic        hlt,
   output logic [2:0]  tstate,
   output logic        busy
);

   // Bit positions inside ctrl_word = {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
   localparam int CP = 11;
   localparam int EP = 10;
   localparam int LM = 9;
   localparam int CE = 8;
   localparam int LI = 7;
   localparam int EI = 6;
   localparam int LA = 5;
   localparam int EA = 4;
   localparam int SU = 3;
   localparam int EU = 2;
   localparam int LB = 1;
   localparam int LO = 0;

   // Encoding doubles as the externally visible T-state number
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_T6   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   state_t state_reg;

   // State register: reset wins over everything; run only matters in IDLE and T6
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg <= S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE:  state_reg <= run ? S_T1 : S_IDLE;
            S_T1:    state_reg <= S_T2;
            S_T2:    state_reg <= S_T3;
            S_T3:    state_reg <= S_T4;
            S_T4:    state_reg <= (ir_op == OP_HLT) ? S_HALT : S_T5;
            S_T5:    state_reg <= S_T6;
            S_T6:    state_reg <= run ? S_T1 : S_IDLE;
            S_HALT:  state_reg <= S_HALT;
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Control-word decode: fetch in T1-T3, opcode-dependent execute in T4-T6.
   // Anything not matched (undefined opcodes, HLT, IDLE, HALT) leaves all bits 0.
   always_comb begin
      ctrl_word = 12'h000;
      pc_load   = 1'b0;
      case (state_reg)
         S_T1: begin
            ctrl_word[EP] = 1'b1;
            ctrl_word[LM] = 1'b1;
         end
         S_T2: begin
            ctrl_word[CP] = 1'b1;
         end
         S_T3: begin
            ctrl_word[CE] = 1'b1;
            ctrl_word[LI] = 1'b1;
         end
         S_T4: begin
            if (ir_op == OP_LDA || ir_op == OP_ADD || ir_op == OP_SUB) begin
               ctrl_word[EI] = 1'b1;
               ctrl_word[LM] = 1'b1;
            end else if (ir_op == OP_OUT) begin
               ctrl_word[EA] = 1'b1;
               ctrl_word[LO] = 1'b1;
`ifdef SEQ_JMP_EN
            end else if (ir_op == OP_JMP) begin
               ctrl_word[EI] = 1'b1;
               pc_load       = 1'b1;
`else
            end else if (ir_op == OP_JMP) begin
               ctrl_word = 12'h000;
`endif
            end
         end
         S_T5: begin
            if (ir_op == OP_LDA) begin
               ctrl_word[CE] = 1'b1;
               ctrl_word[LA] = 1'b1;
            end else if (ir_op == OP_ADD || ir_op == OP_SUB) begin
               ctrl_word[CE] = 1'b1;
               ctrl_word[LB] = 1'b1;
            end
         end
         S_T6: begin
            if (ir_op == OP_ADD || ir_op == OP_SUB) begin
               ctrl_word[EU] = 1'b1;
               ctrl_word[LA] = 1'b1;
               ctrl_word[SU] = (ir_op == OP_SUB);
            end
         end
         default: begin
            ctrl_word = 12'h000;
         end
      endcase
   end

   // Status outputs follow the registered state directly
   always_comb begin
      tstate = state_reg;
      hlt    = (state_reg == S_HALT);
      busy   = (state_reg != S_IDLE) && (state_reg != S_HALT);
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer.
// Expected per-cycle outputs {tstate, ctrl_word, pc_load, hlt, busy} are queued
// when stimulus is applied and popped/compared on the falling clock edge.
// Define SEQ_JMP_EN for both bench and RTL to check the jump build.
module tb_control_sequencer;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        run;
   logic [3:0]  ir_op;
   logic [11:0] ctrl_word;
   logic        pc_load;
   logic        hlt;
   logic [2:0]  tstate;
   logic        busy;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_JMP = 4'b0011;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;
   localparam logic [3:0] OP_NOP = 4'b0111;

   localparam logic [11:0] B_CP = 12'h800;
   localparam logic [11:0] B_EP = 12'h400;
   localparam logic [11:0] B_LM = 12'h200;
   localparam logic [11:0] B_CE = 12'h100;
   localparam logic [11:0] B_LI = 12'h080;
   localparam logic [11:0] B_EI = 12'h040;
   localparam logic [11:0] B_LA = 12'h020;
   localparam logic [11:0] B_EA = 12'h010;
   localparam logic [11:0] B_SU = 12'h008;
   localparam logic [11:0] B_EU = 12'h004;
   localparam logic [11:0] B_LB = 12'h002;
   localparam logic [11:0] B_LO = 12'h001;

`ifdef SEQ_JMP_EN
   localparam bit JMP_EN = 1'b1;
`else
   localparam bit JMP_EN = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   logic [17:0] exp_q[$];
   logic [17:0] obs;
   logic [17:0] e;

   assign obs = {tstate, ctrl_word, pc_load, hlt, busy};

   control_sequencer dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .run       (run),
      .ir_op     (ir_op),
      .ctrl_word (ctrl_word),
      .pc_load   (pc_load),
      .hlt       (hlt),
      .tstate    (tstate),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   // Pack one expected observation; busy is high exactly for T1..T6
   function automatic logic [17:0] pk(int ts, logic [11:0] cw, logic pl, logic h);
      logic [2:0] t3;
      logic       b;
      t3 = 3'(ts);
      b  = (ts >= 1) && (ts <= 6);
      return {t3, cw, pl, h, b};
   endfunction

   // Reference control word for opcode op in T-state t
   function automatic logic [11:0] exp_cw(logic [3:0] op, int t);
      logic [11:0] cw;
      cw = 12'h000;
      case (t)
         1: cw = B_EP | B_LM;
         2: cw = B_CP;
         3: cw = B_CE | B_LI;
         4: begin
            if (op == OP_LDA || op == OP_ADD || op == OP_SUB) cw = B_EI | B_LM;
            else if (op == OP_OUT)                          cw = B_EA | B_LO;
            else if (op == OP_JMP && JMP_EN)                cw = B_EI;
         end
         5: begin
            if (op == OP_LDA)                      cw = B_CE | B_LA;
            else if (op == OP_ADD || op == OP_SUB) cw = B_CE | B_LB;
         end
         6: begin
            if (op == OP_ADD)      cw = B_EU | B_LA;
            else if (op == OP_SUB) cw = B_EU | B_LA | B_SU;
         end
         default: cw = 12'h000;
      endcase
      return cw;
   endfunction

   function automatic logic exp_pl(logic [3:0] op, int t);
      return JMP_EN && (t == 4) && (op == OP_JMP);
   endfunction

   task automatic push_instr(logic [3:0] op);
      for (int t = 1; t <= 6; t++) exp_q.push_back(pk(t, exp_cw(op, t), exp_pl(op, t), 1'b0));
   endtask

   // Reset with run high must still land in IDLE with all outputs quiet
   task automatic test_reset();
      RESET = 1'b1;
      run   = 1'b1;
      ir_op = OP_ADD;
      exp_q.push_back(pk(0, 12'h000, 1'b0, 1'b0));
      for (int i = 0; i < 2; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset[%0d]: got {ts,cw,pl,hlt,busy}=%h expected %h", i, obs, e);
         end
         exp_q.push_back(e);
      end
      void'(exp_q.pop_front());
      RESET = 1'b0;
      run   = 1'b0;
   endtask

   // One instruction started by a single-cycle run pulse, ending back in IDLE
   task automatic test_instr(string name, logic [3:0] op);
      ir_op = op;
      run   = 1'b1;
      push_instr(op);
      exp_q.push_back(pk(0, 12'h000, 1'b0, 1'b0));
      for (int i = 0; i < 7; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got {ts,cw,pl,hlt,busy}=%h expected %h", name, i, obs, e);
         end
         if (i == 0) run = 1'b0;
      end
   endtask

   // ADD then SUB with run held high across the T6->T1 boundary
   task automatic test_back_to_back();
      ir_op = OP_ADD;
      run   = 1'b1;
      push_instr(OP_ADD);
      push_instr(OP_SUB);
      exp_q.push_back(pk(0, 12'h000, 1'b0, 1'b0));
      for (int i = 0; i < 13; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL b2b[%0d]: got {ts,cw,pl,hlt,busy}=%h expected %h", i, obs, e);
         end
         if (i == 5) ir_op = OP_SUB;
         if (i == 6) run = 1'b0;
      end
   endtask

   // Reset asserted while in T5 aborts to IDLE on the next edge
   task automatic test_reset_mid();
      ir_op = OP_ADD;
      run   = 1'b1;
      for (int t = 1; t <= 5; t++) exp_q.push_back(pk(t, exp_cw(OP_ADD, t), 1'b0, 1'b0));
      exp_q.push_back(pk(0, 12'h000, 1'b0, 1'b0));
      exp_q.push_back(pk(0, 12'h000, 1'b0, 1'b0));
      for (int i = 0; i < 7; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid[%0d]: got {ts,cw,pl,hlt,busy}=%h expected %h", i, obs, e);
         end
         if (i == 0) run = 1'b0;
         if (i == 4) RESET = 1'b1;
         if (i == 5) RESET = 1'b0;
      end
   endtask

   // HLT parks in HALT for good, ignoring run; only reset leaves it
   task automatic test_halt();
      ir_op = OP_HLT;
      run   = 1'b1;
      for (int t = 1; t <= 4; t++) exp_q.push_back(pk(t, exp_cw(OP_HLT, t), 1'b0, 1'b0));
      for (int k = 0; k < 20; k++) exp_q.push_back(pk(7, 12'h000, 1'b0, 1'b1));
      exp_q.push_back(pk(0, 12'h000, 1'b0, 1'b0));
      for (int i = 0; i < 25; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL halt[%0d]: got {ts,cw,pl,hlt,busy}=%h expected %h", i, obs, e);
         end
         if (i == 0) run = 1'b0;
         if (i >= 4) run = ~run;
         if (i == 23) RESET = 1'b1;
      end
      RESET = 1'b0;
      run   = 1'b0;
   endtask

   initial begin
      RESET = 1'b1;
      run   = 1'b0;
      ir_op = 4'b0000;
      test_reset();
      test_instr("lda", OP_LDA);
      test_instr("add", OP_ADD);
      test_instr("sub", OP_SUB);
      test_instr("out", OP_OUT);
      test_instr("jmp", OP_JMP);
      test_instr("nop", OP_NOP);
      test_back_to_back();
      test_reset_mid();
      test_halt();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: got %0d leftover entries expected 0", exp_q.size());
      end
      checks++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
